// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte/word packer and the splitter-side benches.
//   BYTE_W          width of one byte lane
//   BYTES_PER_WORD  lanes per packed word
//   WORD_W          packed word width
//   state_t         FILL (collecting bytes) / HOLD (word presented)
package byte_word_packer_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs bytes MSB-first into a word and presents it with a
// valid/ready handshake. in_last on an accepted byte flushes a partial word
// whose unfilled low lanes are zero.
//
// state | meaning
// FILL  | collecting bytes, in_ready=1, out_valid=0
// HOLD  | word presented,   in_ready=0, out_valid=1
//
// Ports
//   clk         clock, all state updates on posedge
//   reset       asynchronous active-high reset, discards any partial word
//   in_valid    producer offers in_byte
//   in_ready    packer accepts a byte this cycle
//   in_byte     byte data
//   in_last     final byte of a message, flush after it
//   out_valid   out_word/out_nbytes hold a complete or flushed word
//   out_ready   consumer takes the word
//   out_word    packed word, first byte in the top lane
//   out_nbytes  number of valid bytes in out_word, 0 when !out_valid
module byte_word_packer #(
    parameter int BYTE_W         = byte_word_packer_pkg::BYTE_W,
    parameter int BYTES_PER_WORD = byte_word_packer_pkg::BYTES_PER_WORD
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [BYTE_W-1:0]                        in_byte,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]         out_word,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]      out_nbytes
);
    import byte_word_packer_pkg::*;

    localparam int WORD_BITS = BYTE_W * BYTES_PER_WORD;
    localparam int CNT_W     = $clog2(BYTES_PER_WORD + 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WORD_BITS-1:0]   r_word;

    logic                   w_accept;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_word_done;

    assign w_accept    = in_valid && (r_state == ST_FILL);
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_word_done = (w_cnt_next == CNT_W'(BYTES_PER_WORD)) || in_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        // lane index = byte count so far, counted down from the top
                        for (int i = 0; i < BYTES_PER_WORD; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                r_word[WORD_BITS-1-BYTE_W*i -: BYTE_W] <= in_byte;
                            end
                        end
                        r_cnt <= w_cnt_next;
                        if (w_word_done) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_word  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_cnt   <= '0;
                    r_word  <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; nothing from the inputs
    // reaches them combinationally. Partial fill is hidden while collecting.
    assign in_ready   = (r_state == ST_FILL);
    assign out_valid  = (r_state == ST_HOLD);
    assign out_word   = out_valid ? r_word : '0;
    assign out_nbytes = out_valid ? r_cnt  : '0;

endmodule
